// File: rtl/esm_report_arbiter.sv
// Packet-level round-robin arbiter merging ESM report streams onto one AXI-stream master.
// A granted input owns the output until its last word; a stalled input is aborted after a timeout.
module esm_report_arbiter #(
  parameter int unsigned                  AXI_DATA_WIDTH = 32,
  parameter int unsigned                  NUM_INPUTS     = 4,
  parameter int unsigned                  TIMEOUT_CYCLES = 1024,
  parameter logic [AXI_DATA_WIDTH-1:0]    ABORT_WORD     = 32'hDEADBEEF
) (
  input  logic                                 Axi_clk,
  input  logic                                 Axi_rstn,
  input  logic [NUM_INPUTS-1:0]                S_axis_valid,
  input  logic [NUM_INPUTS*AXI_DATA_WIDTH-1:0] S_axis_data,
  input  logic [NUM_INPUTS-1:0]                S_axis_last,
  output logic [NUM_INPUTS-1:0]                S_axis_ready,
  output logic                                 M_axis_valid,
  output logic [AXI_DATA_WIDTH-1:0]            M_axis_data,
  output logic                                 M_axis_last,
  input  logic                                 M_axis_ready,
  output logic [15:0]                          Abort_count
);

  localparam int unsigned GW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_MATCH = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FWD   = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [GW-1:0]             grant_q, grant_d;
  logic [GW-1:0]             last_grant_q, last_grant_d;
  logic [TW-1:0]             tcnt_q, tcnt_d;
  logic                      m_valid_q, m_valid_d;
  logic [AXI_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                      m_last_q, m_last_d;
  logic [15:0]               abort_cnt_q, abort_cnt_d;

  logic                      slot_free;
  logic                      sel_valid;
  logic                      sel_last;
  logic [AXI_DATA_WIDTH-1:0] sel_data;
  logic                      pick_found;
  logic [GW-1:0]             pick_idx;
  logic                      ready_sel;

  assign slot_free = !m_valid_q || M_axis_ready;

  // Mux of the currently granted input.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (grant_q == GW'(i)) begin
        sel_valid = S_axis_valid[i];
        sel_last  = S_axis_last[i];
        sel_data  = S_axis_data[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      end
    end
  end

  // Round-robin search starting just after the previous grant.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_grant_q;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        if (!pick_found && S_axis_valid[i] &&
            (((32'(last_grant_q) + k + 32'd1) % NUM_INPUTS) == i)) begin
          pick_found = 1'b1;
          pick_idx   = GW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tcnt_d       = tcnt_q;
    m_valid_d    = m_valid_q && !M_axis_ready;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    abort_cnt_d  = abort_cnt_q;
    ready_sel    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          tcnt_d  = '0;
          state_d = ST_FWD;
        end
      end
      ST_FWD: begin
        ready_sel = slot_free;
        if (sel_valid && slot_free) begin
          m_valid_d = 1'b1;
          m_data_d  = sel_data;
          m_last_d  = sel_last;
          tcnt_d    = '0;
          if (sel_last) begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end
        end else if (slot_free && (TIMEOUT_CYCLES != 0)) begin
          // Only cycles where the output could have taken a word count as starvation.
          if (tcnt_q + TW'(1) == TIMEOUT_MATCH) begin
            tcnt_d  = '0;
            state_d = ST_ABORT;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      ST_ABORT: begin
        if (slot_free) begin
          m_valid_d = 1'b1;
          m_data_d  = ABORT_WORD;
          m_last_d  = 1'b1;
          if (abort_cnt_q != 16'hFFFF) abort_cnt_d = abort_cnt_q + 16'd1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        ready_sel = 1'b1;
        if (sel_valid && sel_last) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    S_axis_ready = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (grant_q == GW'(i)) S_axis_ready[i] = ready_sel;
    end
  end

  always_ff @(posedge Axi_clk or negedge Axi_rstn) begin
    if (!Axi_rstn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_INPUTS - 1);
      tcnt_q       <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      abort_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tcnt_q       <= tcnt_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      abort_cnt_q  <= abort_cnt_d;
    end
  end

  assign M_axis_valid = m_valid_q;
  assign M_axis_data  = m_data_q;
  assign M_axis_last  = m_last_q;
  assign Abort_count  = abort_cnt_q;

endmodule
